// File: rtl/cascade_systolic_fir_pkg.sv
// Shared constants for the cascaded systolic 5x5 FIR.
package cascade_systolic_fir_pkg;

    localparam int PIX_W   = 8;
    localparam int COEFF_W = 16;
    localparam int FRAC    = 8;
    localparam int ACC_W   = 32;
    localparam int LATENCY = 10;
    localparam int KERNEL  = 5;
    localparam int TAP_DLY = 2 * (KERNEL - 1);

endpackage

// File: rtl/systolic_mac_cell.sv
// One multiply-accumulate cell of the systolic row chain.
module systolic_mac_cell
    import cascade_systolic_fir_pkg::*;
#(
    parameter int PW = PIX_W,
    parameter int CW = COEFF_W,
    parameter int AW = ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] px_in,
    input  logic [CW-1:0] coeff,
    input  logic [AW-1:0] psum_in,
    output logic [AW-1:0] psum_out
);

    logic [PW-1:0]    px_q;
    logic [PW+CW:0]   px_e;
    logic [PW+CW:0]   cf_e;
    logic [PW+CW:0]   prod;
    logic [AW-1:0]    prod_x;

    // Low bits of an unsigned multiply equal the signed product here.
    assign px_e   = {{(CW + 1){1'b0}}, px_q};
    assign cf_e   = {{(PW + 1){coeff[CW-1]}}, coeff};
    assign prod   = px_e * cf_e;
    assign prod_x = {{(AW - PW - CW - 1){prod[PW+CW]}}, prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_q     <= '0;
            psum_out <= '0;
        end else begin
            px_q     <= px_in;
            psum_out <= prod_x + psum_in;
        end
    end

endmodule

// File: rtl/cascade_systolic_fir.sv
// 5x5 systolic FIR: per-row MAC chains, pipelined row-sum tree,
// floor shift and 0..255 saturation. Fixed 10-cycle latency.
module cascade_systolic_fir
    import cascade_systolic_fir_pkg::*;
#(
    parameter int PIX_W   = cascade_systolic_fir_pkg::PIX_W,
    parameter int COEFF_W = cascade_systolic_fir_pkg::COEFF_W,
    parameter int FRAC    = cascade_systolic_fir_pkg::FRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   pixel0,
    input  logic [PIX_W-1:0]   pixel1,
    input  logic [PIX_W-1:0]   pixel2,
    input  logic [PIX_W-1:0]   pixel3,
    input  logic [PIX_W-1:0]   pixel4,
    input  logic [COEFF_W-1:0] coeff00,
    input  logic [COEFF_W-1:0] coeff01,
    input  logic [COEFF_W-1:0] coeff02,
    input  logic [COEFF_W-1:0] coeff03,
    input  logic [COEFF_W-1:0] coeff04,
    input  logic [COEFF_W-1:0] coeff10,
    input  logic [COEFF_W-1:0] coeff11,
    input  logic [COEFF_W-1:0] coeff12,
    input  logic [COEFF_W-1:0] coeff13,
    input  logic [COEFF_W-1:0] coeff14,
    input  logic [COEFF_W-1:0] coeff20,
    input  logic [COEFF_W-1:0] coeff21,
    input  logic [COEFF_W-1:0] coeff22,
    input  logic [COEFF_W-1:0] coeff23,
    input  logic [COEFF_W-1:0] coeff24,
    input  logic [COEFF_W-1:0] coeff30,
    input  logic [COEFF_W-1:0] coeff31,
    input  logic [COEFF_W-1:0] coeff32,
    input  logic [COEFF_W-1:0] coeff33,
    input  logic [COEFF_W-1:0] coeff34,
    input  logic [COEFF_W-1:0] coeff40,
    input  logic [COEFF_W-1:0] coeff41,
    input  logic [COEFF_W-1:0] coeff42,
    input  logic [COEFF_W-1:0] coeff43,
    input  logic [COEFF_W-1:0] coeff44,
    output logic               out_valid,
    output logic [PIX_W-1:0]   out_pixel
);

    logic [KERNEL-1:0][PIX_W-1:0]   pix;
    logic [KERNEL-1:0][COEFF_W-1:0] cf   [KERNEL];
    logic [TAP_DLY-1:0][PIX_W-1:0]  dly  [KERNEL];
    logic [PIX_W-1:0]               tap  [KERNEL][KERNEL];
    logic [ACC_W-1:0]               cas  [KERNEL][KERNEL];
    logic [ACC_W-1:0]               psum [KERNEL][KERNEL];

    assign pix   = {pixel4, pixel3, pixel2, pixel1, pixel0};
    assign cf[0] = {coeff04, coeff03, coeff02, coeff01, coeff00};
    assign cf[1] = {coeff14, coeff13, coeff12, coeff11, coeff10};
    assign cf[2] = {coeff24, coeff23, coeff22, coeff21, coeff20};
    assign cf[3] = {coeff34, coeff33, coeff32, coeff31, coeff30};
    assign cf[4] = {coeff44, coeff43, coeff42, coeff41, coeff40};

    // Pixels travel two registers per tap while sums move one, so
    // chain position j meets the column sampled j cycles earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < KERNEL; r++) dly[r] <= '0;
        end else begin
            for (int r = 0; r < KERNEL; r++)
                dly[r] <= {dly[r][TAP_DLY-2:0], pix[r]};
        end
    end

    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        for (genvar j = 0; j < KERNEL; j++) begin : g_tap
            if (j == 0) begin : g_head
                assign tap[r][j] = pix[r];
                assign cas[r][j] = '0;
            end else begin : g_body
                assign tap[r][j] = dly[r][2*j-1];
                assign cas[r][j] = psum[r][j-1];
            end
            systolic_mac_cell #(
                .PW (PIX_W),
                .CW (COEFF_W),
                .AW (ACC_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .px_in    (tap[r][j]),
                .coeff    (cf[r][KERNEL-1-j]),
                .psum_in  (cas[r][j]),
                .psum_out (psum[r][j])
            );
        end
    end

    logic [ACC_W-1:0]   s1_0, s1_1, s1_2;
    logic [ACC_W-1:0]   s2_0, s2_1;
    logic [ACC_W-1:0]   acc_q, shf_q;
    logic [PIX_W-1:0]   sat_pix;
    logic [LATENCY-1:0] vld_q;

    always_comb begin
        sat_pix = shf_q[PIX_W-1:0];
        if (shf_q[ACC_W-1])
            sat_pix = '0;
        else if (|shf_q[ACC_W-2:PIX_W])
            sat_pix = '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_0      <= '0;
            s1_1      <= '0;
            s1_2      <= '0;
            s2_0      <= '0;
            s2_1      <= '0;
            acc_q     <= '0;
            shf_q     <= '0;
            out_pixel <= '0;
            vld_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_0      <= psum[0][KERNEL-1] + psum[1][KERNEL-1];
            s1_1      <= psum[2][KERNEL-1] + psum[3][KERNEL-1];
            s1_2      <= psum[4][KERNEL-1];
            s2_0      <= s1_0 + s1_1;
            s2_1      <= s1_2;
            acc_q     <= s2_0 + s2_1;
            shf_q     <= $signed(acc_q) >>> FRAC;
            out_pixel <= sat_pix;
            vld_q     <= {vld_q[LATENCY-2:0], in_valid};
            out_valid <= vld_q[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_cascade_systolic_fir.sv
// Directed bench for cascade_systolic_fir with hand-derived results.
module tb_cascade_systolic_fir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  px [5];
    logic [15:0] cf [5][5];
    logic        out_valid;
    logic [7:0]  out_pixel;
    int          n_run = 0;
    int          n_fail = 0;

    int tbl [7][5] = '{
        '{0, 5, 9, 4, 0},
        '{1, 6, 8, 3, 1},
        '{2, 7, 7, 2, 2},
        '{3, 8, 6, 1, 3},
        '{4, 9, 5, 0, 4},
        '{4, 9, 5, 0, 4},
        '{3, 8, 6, 1, 3}
    };
    // Windows ending at columns 0..6 (zeros before column 0).
    int exp_win [7] = '{0, 0, 168, 122, 75, 46, 19};

    always #5 clk = ~clk;

    cascade_systolic_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pixel0    (px[0]),
        .pixel1    (px[1]),
        .pixel2    (px[2]),
        .pixel3    (px[3]),
        .pixel4    (px[4]),
        .coeff00   (cf[0][0]),
        .coeff01   (cf[0][1]),
        .coeff02   (cf[0][2]),
        .coeff03   (cf[0][3]),
        .coeff04   (cf[0][4]),
        .coeff10   (cf[1][0]),
        .coeff11   (cf[1][1]),
        .coeff12   (cf[1][2]),
        .coeff13   (cf[1][3]),
        .coeff14   (cf[1][4]),
        .coeff20   (cf[2][0]),
        .coeff21   (cf[2][1]),
        .coeff22   (cf[2][2]),
        .coeff23   (cf[2][3]),
        .coeff24   (cf[2][4]),
        .coeff30   (cf[3][0]),
        .coeff31   (cf[3][1]),
        .coeff32   (cf[3][2]),
        .coeff33   (cf[3][3]),
        .coeff34   (cf[3][4]),
        .coeff40   (cf[4][0]),
        .coeff41   (cf[4][1]),
        .coeff42   (cf[4][2]),
        .coeff43   (cf[4][3]),
        .coeff44   (cf[4][4]),
        .out_valid (out_valid),
        .out_pixel (out_pixel)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cf(input logic [15:0] all, input logic [15:0] c22);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                cf[r][c] = all;
        cf[2][2] = c22;
    endtask

    task automatic set_col(input int a, input int b, input int c,
                           input int d, input int e);
        px[0] = 8'(a);
        px[1] = 8'(b);
        px[2] = 8'(c);
        px[3] = 8'(d);
        px[4] = 8'(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_flat(input int p, input int n);
        set_col(p, p, p, p, p);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        set_cf(16'h0000, 16'h0000);
        set_col(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pixel", 32'(out_pixel), 0);
        chk("rst_valid", 32'(out_valid), 0);

        // Mixed kernel with a 3-cycle valid pulse.
        set_cf(16'hFF00, 16'h1800);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 17; t++) begin
            if (t < 7)
                set_col(tbl[t][0], tbl[t][1], tbl[t][2],
                        tbl[t][3], tbl[t][4]);
            else
                set_col(0, 0, 0, 0, 0);
            in_valid = (t < 3);
            tick();
            if (t >= 10)
                chk($sformatf("win_t%0d", t), 32'(out_pixel),
                    32'(exp_win[t-10]));
            if (t >= 8 && t <= 14)
                chk($sformatf("vld_t%0d", t), 32'(out_valid),
                    32'(t >= 10 && t <= 12));
        end

        // Identity kernel; stream valid columns then reset mid-stream.
        set_cf(16'h0000, 16'h0100);
        for (int t = 0; t < 14; t++) begin
            set_col(77, 77, 100 + t, 77, 77);
            in_valid = 1'b1;
            tick();
        end
        chk("pre_rst_pixel", 32'(out_pixel), 101);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b0;
        #2;
        chk("async_rst_pixel", 32'(out_pixel), 0);
        chk("async_rst_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 20; t++) begin
            set_col(200, 200, 10 + 3 * t, 200, 200);
            tick();
            chk($sformatf("ramp_t%0d", t), 32'(out_pixel),
                (t >= 12) ? 32'(10 + 3 * (t - 12)) : 32'd0);
            chk($sformatf("ramp_vld_t%0d", t), 32'(out_valid), 0);
        end

        // Full-window sums, saturation and the floor shift.
        set_cf(16'h0100, 16'h0100);
        run_flat(255, 15);
        chk("sat_high", 32'(out_pixel), 255);
        run_flat(10, 15);
        chk("sum_250", 32'(out_pixel), 250);
        run_flat(11, 15);
        chk("sat_275", 32'(out_pixel), 255);
        set_cf(16'hFF00, 16'hFF00);
        run_flat(100, 15);
        chk("sat_low", 32'(out_pixel), 0);
        set_cf(16'h0000, 16'h0080);
        run_flat(3, 15);
        chk("floor_1p5", 32'(out_pixel), 1);
        set_cf(16'h0000, 16'h0180);
        run_flat(3, 15);
        chk("floor_4p5", 32'(out_pixel), 4);
        set_cf(16'h0000, 16'h0100);
        cf[0][0] = 16'hFFFF;
        run_flat(10, 15);
        chk("neg_coeff", 32'(out_pixel), 9);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
